// File: rtl/dice_pkg.sv
// dice_pkg: shared types for dice capture and game logic.
//   state_t   - capture FSM states
//   dice_t    - 2-bit dice face (0 = none, 1..3 = face)
//   DICE_NONE - "no colour detected" face value
package dice_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SAMPLE,
        S_EMIT,
        S_WAIT_CLEAR
    } state_t;

    typedef logic [1:0] dice_t;

    localparam dice_t DICE_NONE = 2'd0;

endpackage

// File: rtl/dice_capture_ctrl_cycle_timer.sv
// cycle_timer: saturating cycle counter with an expire pulse at TIMEOUT_CYC-1.
//   clk, reset - clock, asynchronous active-high reset
//   clear_i    - synchronous clear back to zero (dominates en_i)
//   en_i       - count this cycle
//   expire_o   - high in the TIMEOUT_CYC-th enabled cycle after a clear
module cycle_timer #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int W = $clog2(TIMEOUT_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb
        cnt_d = clear_i ? '0 : (en_i && cnt_q != W'(TIMEOUT_CYC)) ? cnt_q + W'(1) : cnt_q;

    assign expire_o = en_i && !clear_i && cnt_q == W'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;

endmodule

// File: rtl/dice_capture_ctrl.sv
// dice_capture_ctrl: arms on enable, waits for the on-turn roll request, then
// debounces colour samples into a single accepted dice roll.
//   clk, reset             - clock, asynchronous active-high reset
//   enable                 - game waiting for a result; low aborts capture
//   turn                   - current player (0 = p1, 1 = p2)
//   roll_req_p1/p2         - single-cycle roll requests
//   color_ready/value      - colour sample strobe and detected face
//   dice_valid/dice_value  - accepted-roll pulse and held face
//   capturing              - high while sampling
//   timeout, wrong_player  - single-cycle status pulses
module dice_capture_ctrl
    import dice_pkg::*;
#(
    parameter int STABLE_COUNT = 4,
    parameter int CLEAR_COUNT  = 4,
    parameter int TIMEOUT_CYC  = 100_000_000
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  enable,
    input  logic  turn,
    input  logic  roll_req_p1,
    input  logic  roll_req_p2,
    input  logic  color_ready,
    input  dice_t color_value,
    output logic  dice_valid,
    output dice_t dice_value,
    output logic  capturing,
    output logic  timeout,
    output logic  wrong_player
);

    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam int CW = $clog2(CLEAR_COUNT + 1);

    state_t        state_q, state_d;
    dice_t         cand_q, cand_d, value_q, value_d, cand_nx;
    logic [MW-1:0] match_q, match_d, match_nx;
    logic [CW-1:0] clr_q, clr_d;
    logic          valid_q, valid_d, tmo_q, tmo_d, wrong_q, wrong_d;
    logic          expire, req_mine, req_other;

    cycle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != S_SAMPLE),
        .en_i     (state_q == S_SAMPLE),
        .expire_o (expire)
    );

    assign req_mine  = turn ? roll_req_p2 : roll_req_p1;
    assign req_other = turn ? roll_req_p1 : roll_req_p2;

    // Match count is the length of the trailing run of identical non-zero samples.
    always_comb begin
        cand_nx  = cand_q;
        match_nx = match_q;
        if (color_value == DICE_NONE) begin
            match_nx = '0;
        end else if (color_value != cand_q) begin
            cand_nx  = color_value;
            match_nx = MW'(1);
        end else if (match_q != MW'(STABLE_COUNT)) begin
            match_nx = match_q + MW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        clr_d   = clr_q;
        value_d = value_q;
        valid_d = 1'b0;
        tmo_d   = 1'b0;
        wrong_d = 1'b0;
        case (state_q)
            S_IDLE: state_d = enable ? S_ARMED : S_IDLE;
            S_ARMED: begin
                if (!enable)        state_d = S_IDLE;
                else if (req_mine)  state_d = S_SAMPLE;
                else if (req_other) wrong_d = 1'b1;
            end
            S_SAMPLE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else begin
                    if (color_ready) begin
                        cand_d  = cand_nx;
                        match_d = match_nx;
                        if (match_nx == MW'(STABLE_COUNT)) begin
                            state_d = S_EMIT;
                            value_d = cand_nx;
                            valid_d = 1'b1;
                        end
                    end
                    // An accept in the expiry cycle takes priority over the timeout.
                    if (state_d == S_SAMPLE && expire) begin
                        state_d = S_ARMED;
                        tmo_d   = 1'b1;
                    end
                end
            end
            // The accept pulse always completes, even if enable drops.
            S_EMIT: state_d = S_WAIT_CLEAR;
            S_WAIT_CLEAR: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (color_ready) begin
                    if (color_value == DICE_NONE) begin
                        clr_d = (clr_q == CW'(CLEAR_COUNT)) ? clr_q : clr_q + CW'(1);
                        if (clr_d == CW'(CLEAR_COUNT)) state_d = S_IDLE;
                    end else begin
                        clr_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != S_SAMPLE) begin
            cand_d  = DICE_NONE;
            match_d = '0;
        end
        if (state_d != S_WAIT_CLEAR) clr_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cand_q  <= DICE_NONE;
            match_q <= '0;
            clr_q   <= '0;
            value_q <= DICE_NONE;
            valid_q <= 1'b0;
            tmo_q   <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            clr_q   <= clr_d;
            value_q <= value_d;
            valid_q <= valid_d;
            tmo_q   <= tmo_d;
            wrong_q <= wrong_d;
        end
    end

    assign dice_valid   = valid_q;
    assign dice_value   = value_q;
    assign capturing    = state_q == S_SAMPLE;
    assign timeout      = tmo_q;
    assign wrong_player = wrong_q;

endmodule

// File: tb/tb_dice_capture_ctrl.sv
// tb_dice_capture_ctrl: scoreboard bench for dice_capture_ctrl (3/2/20 config).
module tb_dice_capture_ctrl;

    localparam int SC = 3;
    localparam int CC = 2;
    localparam int TC = 20;

    localparam int EV_VALID = 4;
    localparam int EV_TMO   = 2;
    localparam int EV_WRONG = 1;

    localparam int P_IDLE = 0;
    localparam int P_ARMED = 1;
    localparam int P_SAMP = 2;
    localparam int P_EMIT = 3;
    localparam int P_WAIT = 4;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       turn = 1'b0;
    logic       roll_req_p1 = 1'b0;
    logic       roll_req_p2 = 1'b0;
    logic       color_ready = 1'b0;
    logic [1:0] color_value = 2'd0;
    logic       dice_valid, capturing, timeout, wrong_player;
    logic [1:0] dice_value;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   ph = P_IDLE;
    int   last_val = 0;
    int   tcnt = 0;
    int   samples[$];
    int   clears[$];
    ev_t  sb[$];

    dice_capture_ctrl #(.STABLE_COUNT(SC), .CLEAR_COUNT(CC), .TIMEOUT_CYC(TC)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .turn         (turn),
        .roll_req_p1  (roll_req_p1),
        .roll_req_p2  (roll_req_p2),
        .color_ready  (color_ready),
        .color_value  (color_value),
        .dice_valid   (dice_valid),
        .dice_value   (dice_value),
        .capturing    (capturing),
        .timeout      (timeout),
        .wrong_player (wrong_player)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    // True when the last n entries exist and all equal the newest one, which
    // must be zero (want_zero) or non-zero.
    function automatic bit tail_run(input int s[$], input int n, input bit want_zero);
        int last;
        if (s.size() < n) return 1'b0;
        last = s[s.size()-1];
        if ((last == 0) != want_zero) return 1'b0;
        for (int i = s.size() - n; i < s.size(); i++)
            if (s[i] != last) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void push_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.cyc  = cyc;
        sb.push_back(e);
    endfunction

    // Reference model: follows the rules at event level, sampled at each rising edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            ph = P_IDLE;
            last_val = 0;
        end else begin
            case (ph)
                P_IDLE: if (enable) ph = P_ARMED;
                P_ARMED: begin
                    if (!enable) ph = P_IDLE;
                    else if (turn ? roll_req_p2 : roll_req_p1) begin
                        ph = P_SAMP;
                        samples.delete();
                        tcnt = 0;
                    end else if (turn ? roll_req_p1 : roll_req_p2) push_ev(EV_WRONG, 0);
                end
                P_SAMP: begin
                    if (!enable) ph = P_IDLE;
                    else begin
                        if (color_ready) samples.push_back(int'(color_value));
                        if (color_ready && tail_run(samples, SC, 1'b0)) begin
                            last_val = samples[samples.size()-1];
                            push_ev(EV_VALID, last_val);
                            ph = P_EMIT;
                        end else if (tcnt == TC - 1) begin
                            push_ev(EV_TMO, 0);
                            ph = P_ARMED;
                        end
                        tcnt++;
                    end
                end
                P_EMIT: begin
                    ph = P_WAIT;
                    clears.delete();
                end
                default: begin
                    if (!enable) ph = P_IDLE;
                    else if (color_ready) begin
                        clears.push_back(int'(color_value));
                        if (tail_run(clears, CC, 1'b1)) ph = P_IDLE;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the expected event for this cycle and compares with DUT pulses.
    initial forever begin
        int  got, exp_k, exp_v;
        ev_t e;
        @(negedge clk);
        if (reset) begin
            chk("reset_outputs", int'({dice_valid, dice_value, capturing, timeout, wrong_player}), 0);
        end else begin
            chk("capturing", int'(capturing), int'(ph == P_SAMP));
            got = int'({dice_valid, timeout, wrong_player});
            exp_k = 0;
            exp_v = 0;
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                exp_k = e.kind;
                exp_v = e.val;
            end
            if (got != 0 || exp_k != 0) begin
                chk("event_kind", got, exp_k);
                if (exp_k == EV_VALID) chk("dice_value", int'(dice_value), exp_v);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        roll_req_p1 = 1'b0;
        roll_req_p2 = 1'b0;
        color_ready = 1'b0;
    endtask

    task automatic samp(input int v);
        color_ready = 1'b1;
        color_value = 2'(v);
        tick();
    endtask

    task automatic req(input bit p1, input bit p2);
        roll_req_p1 = p1;
        roll_req_p2 = p2;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int prev;
        idle(3);
        reset = 1'b0;
        enable = 1'b1;
        turn = 1'b0;
        tick();

        // Basic capture of face 2, then clear back to idle.
        req(1, 0);
        samp(2); samp(2); samp(2);
        tick();
        samp(0); samp(0);
        tick();

        // Off-turn request flags wrong_player; on-turn request starts sampling.
        turn = 1'b1;
        req(1, 0);
        tick();
        req(0, 1);
        samp(1); samp(1); samp(1);
        tick();
        samp(0); samp(3); samp(0); samp(0);
        tick();

        // Both requests together: the matching one wins.
        turn = 1'b0;
        req(1, 1);
        samp(1); samp(1); samp(3); samp(3); samp(0); samp(3); samp(3); samp(3);
        tick();
        samp(0); samp(0);
        tick();

        // No samples at all: timeout back to armed.
        req(1, 0);
        idle(25);

        // Abort mid-capture, then a single sample must not accept.
        req(1, 0);
        samp(2); samp(2);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        req(1, 0);
        samp(2);
        idle(3);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // Reset mid-capture discards the candidate.
        req(1, 0);
        samp(3); samp(3);
        reset = 1'b1;
        #2;
        chk("reset_state", int'({dice_valid, dice_value, capturing, timeout, wrong_player}), 0);
        idle(2);
        reset = 1'b0;
        tick();
        req(1, 0);
        samp(3); samp(3); samp(3);
        tick();
        samp(0); samp(0);
        tick();

        // Randomised traffic.
        prev = 1;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 39) != 0);
            if ($urandom_range(0, 19) == 0) turn = ~turn;
            roll_req_p1 = ($urandom_range(0, 5) == 0);
            roll_req_p2 = ($urandom_range(0, 5) == 0);
            color_ready = 1'($urandom_range(0, 1));
            color_value = ($urandom_range(0, 2) == 0) ? 2'(prev) : 2'($urandom_range(0, 3));
            prev = int'(color_value);
            tick();
        end

        enable = 1'b1;
        idle(3);
        @(negedge clk);
        #1;
        chk("pending_events", sb.size(), 0);
        chk("dice_value_hold", int'(dice_value), last_val);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dice_capture_ctrl.md
DICE_CAPTURE_CTRL -- requirements
Module: dice_capture_ctrl

Interface
REQ-001 Parameter STABLE_COUNT, default 4: consecutive identical non-zero color samples required to accept a roll.
REQ-002 Parameter CLEAR_COUNT, default 4: consecutive zero color samples required before re-arming.
REQ-003 Parameter TIMEOUT_CYC, default 100_000_000: cycles allowed in sampling (1 s at 100 MHz).
REQ-004 clk  input  1  system clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  game is waiting for a dice result; low aborts any capture.
REQ-007 turn  input  1  current player: 0 = p1, 1 = p2.
REQ-008 roll_req_p1  input  1  single-cycle roll request, player 1.
REQ-009 roll_req_p2  input  1  single-cycle roll request, player 2.
REQ-010 color_ready  input  1  color sample strobe from color detection.
REQ-011 color_value  input  2  detected color: 0 = none, 1..3 = dice face.
REQ-012 dice_valid  output  1  single-cycle accepted-roll pulse to game logic.
REQ-013 dice_value  output  2  accepted face; held until next accept.
REQ-014 capturing  output  1  high while in S_SAMPLE.
REQ-015 timeout  output  1  single-cycle pulse on sampling timeout.
REQ-016 wrong_player  output  1  single-cycle pulse when the off-turn player requests while armed.

Function
REQ-017 FSM states: S_IDLE, S_ARMED, S_SAMPLE, S_EMIT, S_WAIT_CLEAR.
REQ-018 S_IDLE -> S_ARMED when enable=1; candidate, match counter, clear counter and timer all zero.
REQ-019 S_ARMED: roll_req of player matching turn -> S_SAMPLE; off-turn request -> wrong_player pulse next cycle, stay in S_ARMED.
REQ-020 Both requests in the same cycle: matching request accepted, wrong_player not asserted.
REQ-021 S_SAMPLE: only cycles with color_ready=1 are samples; non-ready cycles leave the counters unchanged.
REQ-022 Sample value 0: match count resets to 0. Non-zero value different from candidate: candidate := value, count := 1. Value equal to candidate: count += 1.
REQ-023 When count reaches STABLE_COUNT -> S_EMIT; dice_value := candidate, and dice_valid is high for exactly the following cycle (S_EMIT, 1 cycle) -> S_WAIT_CLEAR.
REQ-024 Timer counts every S_SAMPLE cycle from 0; reaching TIMEOUT_CYC-1 without accept -> timeout pulse, -> S_ARMED. Accept in the same cycle as timer expiry wins (no timeout).
REQ-025 S_WAIT_CLEAR: CLEAR_COUNT consecutive color_ready samples with value 0 -> S_IDLE; any non-zero sample resets the clear count.
REQ-026 enable=0 in any state other than S_EMIT -> S_IDLE next cycle, no pulses; S_EMIT always completes its pulse.
REQ-027 Counter widths are $clog2(param+1); counters saturate and never wrap.
REQ-028 dice_valid, timeout and wrong_player are mutually exclusive and registered (no combinational path from inputs).

Reset
REQ-029 On reset: state S_IDLE, dice_valid=0, dice_value=0, capturing=0, timeout=0, wrong_player=0, all counters and candidate cleared.
REQ-030 Reset asserted mid-capture discards the candidate; no dice_valid is produced after release until a new full capture completes.

Structure
REQ-031 Shared package dice_pkg holds the state enum, dice_t (2-bit face type) and the DICE_NONE=0 constant; game logic imports the same dice_t.
REQ-032 One sub-module, cycle_timer (load/clear, enable, expire pulse at TIMEOUT_CYC-1), implements the sampling timeout; everything else stays in dice_capture_ctrl.

Verification (STABLE_COUNT=3, CLEAR_COUNT=2, TIMEOUT_CYC=20)
REQ-033 enable=1, turn=0, roll_req_p1, samples 2,2,2 -> dice_valid one cycle, dice_value=2; then samples 0,0 -> S_IDLE.
REQ-034 turn=1, roll_req_p1 while armed -> wrong_player one cycle, capturing stays 0; then roll_req_p2 -> capturing=1.
REQ-035 Samples 1,1,3,3,0,3,3,3 -> single dice_valid with dice_value=3, after the 8th sample.
REQ-036 Arm and request, no color_ready for 20 cycles -> timeout pulse on cycle 20, state S_ARMED, dice_valid never asserted.
REQ-037 Samples 2,2 then enable=0 -> S_IDLE next cycle; re-enable, request, sample 2 once -> no dice_valid.
REQ-038 Reset asserted after samples 3,3 -> all outputs 0; after release a full 3,3,3 sequence is needed to produce dice_valid.
